// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end with a prefetch queue feeding the ID stage.
// Requests run ahead of decode; a redirect discards queued and in-flight beats.
module if_prefetch_queue #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               freeze_i,
    input  logic               is_branch_i,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  branch_address_i,
    output logic               imem_req_valid_o,
    input  logic               imem_req_ready_i,
    output logic [ADDR_W-1:0]  imem_req_addr_o,
    input  logic               imem_resp_valid_i,
    input  logic [INSTR_W-1:0] imem_resp_data_i,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [INSTR_W-1:0] instruction_o,
    output logic               valid_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  resp_pc_q, resp_pc_d;
    logic [CW-1:0]      count_q, count_d;
    logic [CW-1:0]      outst_q, outst_d;
    logic [CW-1:0]      drop_q, drop_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;

    logic [ADDR_W-1:0]  qpc_q   [DEPTH];
    logic [INSTR_W-1:0] qinstr_q[DEPTH];

    logic [CW:0] used;
    logic        req_valid;
    logic        req_fire;
    logic        resp_acc;
    logic        enq;
    logic        pop;

    // Credit is reserved at request time so the queue can never overflow.
    assign used      = {1'b0, count_q} + {1'b0, outst_q};
    assign req_valid = rst_ni && !is_branch_i && (used < (CW+1)'(DEPTH));
    assign req_fire  = req_valid && imem_req_ready_i;
    assign resp_acc  = imem_resp_valid_i && (outst_q != '0);
    assign enq       = resp_acc && (drop_q == '0) && !is_branch_i;
    assign pop       = !flush_i && !freeze_i && !is_branch_i && (count_q != '0);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q + CW'(req_fire) - CW'(resp_acc);
        drop_d     = drop_q;
        count_d    = count_q + CW'(enq) - CW'(pop);
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d   = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
        if (req_fire) fetch_pc_d = fetch_pc_q + STEP;
        if (enq) resp_pc_d = resp_pc_q + STEP;
        if (resp_acc && (drop_q != '0)) drop_d = drop_q - CW'(1);
        if (is_branch_i) begin
            fetch_pc_d = branch_address_i;
            resp_pc_d  = branch_address_i;
            drop_d     = outst_q - CW'(resp_acc);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush_i) begin
            pc_d    = '0;
            instr_d = '0;
            valid_d = 1'b0;
        end else if (!freeze_i) begin
            if (pop) begin
                pc_d    = qpc_q[rd_ptr_q];
                instr_d = qinstr_q[rd_ptr_q];
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            pc_q       <= '0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            qpc_q[wr_ptr_q]    <= resp_pc_q;
            qinstr_q[wr_ptr_q] <= imem_resp_data_i;
        end
    end

    assign imem_req_valid_o = req_valid;
    assign imem_req_addr_o  = fetch_pc_q;
    assign pc_o             = pc_q;
    assign instruction_o    = instr_q;
    assign valid_o          = valid_q;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Random and directed stimulus for if_prefetch_queue against a queue-based
// reference model and an in-order memory with per-request latency.
module tb_if_prefetch_queue;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        freeze_i = 1'b0;
    logic        is_branch_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] branch_address_i = '0;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b0;
    logic [31:0] imem_req_addr_o;
    logic        imem_resp_valid_i = 1'b0;
    logic [31:0] imem_resp_data_i = '0;
    logic [31:0] pc_o;
    logic [31:0] instruction_o;
    logic        valid_o;

    if_prefetch_queue dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .freeze_i         (freeze_i),
        .is_branch_i      (is_branch_i),
        .flush_i          (flush_i),
        .branch_address_i (branch_address_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_resp_valid_i(imem_resp_valid_i),
        .imem_resp_data_i (imem_resp_data_i),
        .pc_o             (pc_o),
        .instruction_o    (instruction_o),
        .valid_o          (valid_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_due = 0;
    mreq_t mq[$];

    // reference model
    entry_t      m_q[$];
    logic [31:0] m_fpc, m_rpc, m_pc, m_instr;
    bit          m_valid;
    int          m_out, m_drop;

    bit          obs_valid;
    logic [31:0] obs_pc;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic model_reset();
        m_q.delete();
        mq.delete();
        m_fpc = 32'h0;
        m_rpc = 32'h0;
        m_pc = '0;
        m_instr = '0;
        m_valid = 0;
        m_out = 0;
        m_drop = 0;
        last_due = cyc;
    endtask

    task automatic cycle(input bit fz, input bit fl, input bit br,
                         input bit rdy, input logic [31:0] ba,
                         input int lat);
        bit resp, exp_req, fire, racc, do_pop;
        logic [31:0] rdata;
        @(negedge clk_i);
        resp  = (mq.size() > 0) && (mq[0].due <= cyc);
        rdata = resp ? mem_data(mq[0].addr) : 32'h0;
        freeze_i          = fz;
        flush_i           = fl;
        is_branch_i       = br;
        imem_req_ready_i  = rdy;
        branch_address_i  = ba;
        imem_resp_valid_i = resp;
        imem_resp_data_i  = rdata;
        #1;
        obs_valid = valid_o;
        obs_pc    = pc_o;
        exp_req = !br && (m_q.size() + m_out < DEPTH);
        chk("req_valid", {63'd0, imem_req_valid_o}, {63'd0, exp_req});
        if (exp_req) chk("req_addr", {32'd0, imem_req_addr_o}, {32'd0, m_fpc});
        chk("valid", {63'd0, valid_o}, {63'd0, m_valid});
        chk("pc", {32'd0, pc_o}, {32'd0, m_pc});
        chk("instr", {32'd0, instruction_o}, {32'd0, m_instr});

        fire   = exp_req && rdy;
        racc   = resp && (m_out > 0);
        do_pop = !fl && !fz && !br && (m_q.size() > 0);
        if (fl) begin
            m_pc = '0;
            m_instr = '0;
            m_valid = 0;
        end else if (!fz) begin
            if (do_pop) begin
                m_pc = m_q[0].pc;
                m_instr = m_q[0].instr;
                m_valid = 1;
                void'(m_q.pop_front());
            end else begin
                m_valid = 0;
            end
        end
        if (racc) begin
            m_out--;
            if (m_drop > 0) m_drop--;
            else begin
                m_q.push_back('{m_rpc, rdata});
                m_rpc += 32'd4;
            end
        end
        if (fire) begin
            m_fpc += 32'd4;
            m_out++;
        end
        if (br) begin
            m_fpc = ba;
            m_rpc = ba;
            m_q.delete();
            m_drop = m_out;
        end

        if (resp) void'(mq.pop_front());
        if (fire) begin
            last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            mq.push_back('{imem_req_addr_o, last_due});
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        imem_resp_valid_i = 1'b0;
        imem_req_ready_i = 1'b0;
        freeze_i = 1'b0;
        flush_i = 1'b0;
        is_branch_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        cyc += 3;
        model_reset();
        rst_ni = 1'b1;
    endtask

    initial begin
        int seen;
        logic [31:0] got_pc[2];
        model_reset();
        do_reset();

        // warm start with 1-cycle memory
        #1;
        chk("first_req_valid", {63'd0, imem_req_valid_o}, 64'd1);
        chk("first_req_addr", {32'd0, imem_req_addr_o}, 64'h0);
        repeat (20) cycle(0, 0, 0, 1, 32'h0, 1);

        // freeze: prefetch fills up then stops, output holds
        repeat (10) cycle(1, 0, 0, 1, 32'h0, 1);
        chk("freeze_req_stop", {63'd0, imem_req_valid_o}, 64'd0);
        chk("freeze_hold_valid", {63'd0, valid_o}, 64'd1);
        repeat (10) cycle(0, 0, 0, 1, 32'h0, 1);

        // redirect with 3-cycle memory and beats in flight
        repeat (8) cycle(0, 0, 0, 1, 32'h0, 3);
        cycle(0, 1, 1, 1, 32'h100, 3);
        seen = 0;
        for (int i = 0; i < 30 && seen < 2; i++) begin
            cycle(0, 0, 0, 1, 32'h0, 3);
            if (obs_valid) begin
                got_pc[seen] = obs_pc;
                seen++;
            end
        end
        chk("redir_seen", 64'(seen), 64'd2);
        if (seen == 2) begin
            chk("redir_pc0", {32'd0, got_pc[0]}, 64'h100);
            chk("redir_pc1", {32'd0, got_pc[1]}, 64'h104);
        end

        // memory not ready, then flush alone with entries queued
        repeat (5) cycle(0, 0, 0, 0, 32'h0, 1);
        repeat (6) cycle(0, 0, 0, 1, 32'h0, 1);
        repeat (3) cycle(1, 0, 0, 1, 32'h0, 1);
        cycle(0, 1, 0, 1, 32'h0, 1);
        repeat (6) cycle(0, 0, 0, 1, 32'h0, 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 70,
                  $urandom() & 32'hFFFF_FFFC, int'($urandom_range(1, 4)));
        end

        // async reset mid-stream with a full queue
        repeat (12) cycle(1, 0, 0, 1, 32'h0, 1);
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_valid", {63'd0, valid_o}, 64'd0);
        chk("rst_pc", {32'd0, pc_o}, 64'd0);
        chk("rst_instr", {32'd0, instruction_o}, 64'd0);
        chk("rst_req", {63'd0, imem_req_valid_o}, 64'd0);
        do_reset();
        #1;
        chk("post_rst_req", {63'd0, imem_req_valid_o}, 64'd1);
        chk("post_rst_addr", {32'd0, imem_req_addr_o}, 64'h0);
        repeat (20) cycle(0, 0, 0, 1, 32'h0, 2);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
